nios2_system_mult_cell_pipe: RTL and testbench
==============================================

Name: nios2_system_mult_cell_pipe

Overview:
- Parametrised, pipelined DATA_W x DATA_W integer multiplier for the Nios II custom/ALU path, successor to the fixed 32-bit low-word multiply cell.
- Built from four SLICE_W x SLICE_W partial products. Supports the low-word result and all three high-word variants (unsigned x unsigned, signed x unsigned, signed x signed).
- Adds a valid/ready handshake with backpressure, a tag pass-through and a synchronous flush. Sits between the A-stage operand muxes and the writeback result mux.

Parameters:
- DATA_W, 32, operand and result width; must equal 2*SLICE_W.
- SLICE_W, 16, partial-product slice width (hard-multiplier native width).
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside each operation.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  operands/op/tag valid this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- in_src1  input  DATA_W  operand A.
- in_src2  input  DATA_W  operand B.
- in_op  input  2  00 MUL (low word), 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  DATA_W  selected product word.
- out_tag  output  TAG_W  tag of the operation on out_result.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All stage valid bits, out_valid, out_result and out_tag clear to 0.
  - in_ready reads 1 immediately after reset deasserts.
- Pipeline has 3 register stages; latency is 3 cycles from accept (in_valid & in_ready) to out_valid with no stall.
- Global enable: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv = 0, every stage holds its valid, data and tag; inputs are ignored.
  - Bubbles are not compressed.
  - Sustained throughput is 1 op/cycle while out_ready = 1.
- Stage 1:
  - Split operands into lo/hi slices. Lo slices are zero-extended to SLICE_W+1 bits.
  - The A hi slice is sign-extended when in_op is 10 or 11; otherwise it is zero-extended.
  - The B hi slice is sign-extended only when in_op = 11.
  - Register the four signed (2*SLICE_W+2)-bit products ll, lh, hl, hh, plus op, tag and valid.
- Stage 2: p = ll + (lh + hl) << SLICE_W + hh << DATA_W. Compute in 2*DATA_W+2 signed bits and truncate to 2*DATA_W bits. Register p, op, tag and valid.
- Stage 3: out_result = p[DATA_W-1:0] when op = 00, else p[2*DATA_W-1:DATA_W]. Register the result with tag and valid.
- MUL low word is identical for all signedness choices; op 00 uses the unsigned slice extension.
- Flush:
  - On the next edge, clears all three stage valid bits, including a stalled out_valid, regardless of adv.
  - Data and tag registers may keep stale values.
  - An operation presented with in_valid in the same cycle as flush is dropped (not accepted into the pipe).
- out_ready when out_valid = 0 is a don't-care.
- Results are never reordered or duplicated. Each accepted, unflushed op produces exactly one out_valid beat.
- Reset mid-operation discards all in-flight ops with no partial output.

Decomposition:
- Shared package nios2_system_mult_pkg holds:
  - the op encoding constants MUL_OP_LO = 2'b00, MUL_OP_XUU = 2'b01, MUL_OP_XSU = 2'b10, MUL_OP_XSS = 2'b11;
  - the function that derives (a_hi_signed, b_hi_signed) from the op.
- One sub-module is natural: nios2_system_mult_slice, a registered (SLICE_W+1) x (SLICE_W+1) signed multiplier with enable and asynchronous clear, instantiated four times in stage 1.
- The adder tree, result select and handshake control stay in the top.

Test Plan:
- Reset then single op: MUL, A = 0x0001_0003, B = 0x0002_0005, tag = 7 -> out_valid exactly 3 cycles after accept; result 0x000B_000F, out_tag 7.
- High-word modes: A = 0xFFFF_FFFF, B = 0xFFFF_FFFF -> XUU 0xFFFF_FFFE, XSS 0x0000_0000, XSU 0xFFFF_FFFF, MUL 0x0000_0001.
- Boundary operands: A = 0x8000_0000, B = 0x8000_0000 -> XSS 0x4000_0000, XUU 0x4000_0000, XSU 0xC000_0000.
- Back-to-back plus backpressure: 8 consecutive ops with out_ready low for cycles 4-6 -> in_ready low in exactly those cycles; all 8 results in order, none lost or duplicated; throughput returns to 1/cycle.
- Flush: accept 3 ops, assert flush with in_valid high and out_valid stalled -> next cycle out_valid = 0, no results emerge; the op presented with flush is not accepted; a following op completes normally.
- Asynchronous reset asserted mid-stream (between clock edges) -> out_valid drops immediately; out_result = 0 and out_tag = 0; no stale result after release.

Source files
------------

// File: rtl/nios2_system_mult_pkg.sv
// Shared definitions for the pipelined Nios II multiply cell: op encodings
// and the per-op signedness of the operand high slices.
package nios2_system_mult_pkg;

    localparam logic [1:0] MUL_OP_LO  = 2'b00;
    localparam logic [1:0] MUL_OP_XUU = 2'b01;
    localparam logic [1:0] MUL_OP_XSU = 2'b10;
    localparam logic [1:0] MUL_OP_XSS = 2'b11;

    typedef struct packed {
        logic a_hi_signed;
        logic b_hi_signed;
    } mul_sign_t;

    // Low-word MUL uses the unsigned extension; its low word is signedness-agnostic.
    function automatic mul_sign_t mul_hi_sign(input logic [1:0] op);
        mul_sign_t s;
        s.a_hi_signed = (op == MUL_OP_XSU) || (op == MUL_OP_XSS);
        s.b_hi_signed = (op == MUL_OP_XSS);
        return s;
    endfunction

endpackage

// File: rtl/nios2_system_mult_slice.sv
// Registered (SLICE_W+1) x (SLICE_W+1) signed multiplier with enable and
// asynchronous clear; one partial product of the stage-1 array.
module nios2_system_mult_slice #(
    parameter int unsigned SLICE_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_en,
    input  logic [SLICE_W:0]         i_a,
    input  logic [SLICE_W:0]         i_b,
    output logic [2*SLICE_W+1:0]     o_p
);

    localparam int unsigned PP_W = 2 * SLICE_W + 2;

    logic signed [PP_W-1:0] w_a;
    logic signed [PP_W-1:0] w_b;
    logic        [PP_W-1:0] r_p;

    // Full-width sign extension so the product is formed at result width.
    assign w_a = {{(PP_W-SLICE_W-1){i_a[SLICE_W]}}, i_a};
    assign w_b = {{(PP_W-SLICE_W-1){i_b[SLICE_W]}}, i_b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= w_a * w_b;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/nios2_system_mult_cell_pipe.sv
// Three-stage pipelined DATA_W x DATA_W multiplier (low word and three high-word
// variants) with valid/ready backpressure, tag pass-through and flush.
module nios2_system_mult_cell_pipe
    import nios2_system_mult_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SLICE_W = 16,
    parameter int unsigned TAG_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned PP_W   = 2 * SLICE_W + 2;
    localparam int unsigned PROD_W = 2 * DATA_W;

    logic              w_adv;
    mul_sign_t         w_sign;
    logic [SLICE_W:0]  w_a_lo, w_a_hi, w_b_lo, w_b_hi;
    logic [PP_W-1:0]   w_ll, w_lh, w_hl, w_hh;
    logic [PROD_W-1:0] w_ll_x, w_lh_x, w_hl_x, w_hh_x, w_sum;
    logic [DATA_W-1:0] w_sel;

    logic              r_v1, r_v2, r_v3;
    logic [1:0]        r_op1, r_op2;
    logic [TAG_W-1:0]  r_tag1, r_tag2, r_tag3;
    logic [PROD_W-1:0] r_p2;
    logic [DATA_W-1:0] r_res3;

    // Single global enable: the whole pipe stalls when the output is held.
    assign w_adv    = ~r_v3 | out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_sign = mul_hi_sign(in_op);
        w_a_lo = {1'b0, in_src1[SLICE_W-1:0]};
        w_b_lo = {1'b0, in_src2[SLICE_W-1:0]};
        w_a_hi = {w_sign.a_hi_signed & in_src1[DATA_W-1], in_src1[DATA_W-1:SLICE_W]};
        w_b_hi = {w_sign.b_hi_signed & in_src2[DATA_W-1], in_src2[DATA_W-1:SLICE_W]};
    end

    nios2_system_mult_slice #(.SLICE_W(SLICE_W)) u_ll (
        .clk(clk), .reset_n(reset_n), .i_en(w_adv), .i_a(w_a_lo), .i_b(w_b_lo), .o_p(w_ll));
    nios2_system_mult_slice #(.SLICE_W(SLICE_W)) u_lh (
        .clk(clk), .reset_n(reset_n), .i_en(w_adv), .i_a(w_a_lo), .i_b(w_b_hi), .o_p(w_lh));
    nios2_system_mult_slice #(.SLICE_W(SLICE_W)) u_hl (
        .clk(clk), .reset_n(reset_n), .i_en(w_adv), .i_a(w_a_hi), .i_b(w_b_lo), .o_p(w_hl));
    nios2_system_mult_slice #(.SLICE_W(SLICE_W)) u_hh (
        .clk(clk), .reset_n(reset_n), .i_en(w_adv), .i_a(w_a_hi), .i_b(w_b_hi), .o_p(w_hh));

    // The product fits in PROD_W bits, so summing modulo 2^PROD_W is exact.
    always_comb begin
        w_ll_x = {{(PROD_W-PP_W){w_ll[PP_W-1]}}, w_ll};
        w_lh_x = {{(PROD_W-PP_W){w_lh[PP_W-1]}}, w_lh};
        w_hl_x = {{(PROD_W-PP_W){w_hl[PP_W-1]}}, w_hl};
        w_hh_x = {{(PROD_W-PP_W){w_hh[PP_W-1]}}, w_hh};
        w_sum  = w_ll_x + ((w_lh_x + w_hl_x) << SLICE_W) + (w_hh_x << DATA_W);
        w_sel  = (r_op2 == MUL_OP_LO) ? r_p2[DATA_W-1:0] : r_p2[PROD_W-1:DATA_W];
    end

    // Valid chain: flush wins over the enable, so a held output is also killed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op1  <= '0;
            r_tag1 <= '0;
            r_op2  <= '0;
            r_tag2 <= '0;
            r_p2   <= '0;
            r_res3 <= '0;
            r_tag3 <= '0;
        end else if (w_adv) begin
            r_op1  <= in_op;
            r_tag1 <= in_tag;
            r_op2  <= r_op1;
            r_tag2 <= r_tag1;
            r_p2   <= w_sum;
            r_res3 <= w_sel;
            r_tag3 <= r_tag2;
        end
    end

    assign out_valid  = r_v3;
    assign out_result = r_res3;
    assign out_tag    = r_tag3;

endmodule

// File: tb/tb_nios2_system_mult_cell_pipe.sv
// Scoreboard bench for nios2_system_mult_cell_pipe: directed vectors push expected
// results on acceptance; a monitor pops and compares on every output beat.
module tb_nios2_system_mult_cell_pipe;
    import nios2_system_mult_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned SB_W   = DATA_W + TAG_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [1:0]        in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    logic [DATA_W-1:0] exp_res;
    logic [SB_W-1:0]   sb[$];
    int                n_checks = 0;
    int                n_fail   = 0;

    logic [DATA_W-1:0] va[8];
    logic [DATA_W-1:0] vb[8];
    logic [DATA_W-1:0] ve[8];
    logic [1:0]        vo[8];

    always #5 clk = ~clk;

    nios2_system_mult_cell_pipe #(.DATA_W(DATA_W), .SLICE_W(16), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus side of the scoreboard: record every op the DUT accepts.
    always @(negedge clk) begin
        if (reset_n) begin
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back({exp_res, in_tag});
        end
    end

    // Monitor: every output handshake must match the oldest outstanding op.
    always @(negedge clk) begin
        logic [SB_W-1:0] e;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got result 0x%0h tag %0d, expected no beat",
                         out_result, out_tag);
            end else begin
                e = sb.pop_front();
                chk("result", 64'(out_result), 64'(e[SB_W-1:TAG_W]));
                chk("tag", 64'(out_tag), 64'(e[TAG_W-1:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [4:0] tag, input logic [31:0] exp);
        bit ok;
        in_src1  = a;
        in_src2  = b;
        in_op    = op;
        in_tag   = tag;
        exp_res  = exp;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("issue_timeout", 64'(0), 64'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        step();
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int lat;
        int k;
        va = '{32'h0000_0002, 32'h0001_0000, 32'h0001_0000, 32'h0000_0007,
               32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000};
        vb = '{32'h0000_0003, 32'h0001_0000, 32'h0001_0000, 32'h0000_0009,
               32'h0000_0003, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002};
        vo = '{MUL_OP_LO, MUL_OP_LO, MUL_OP_XUU, MUL_OP_LO,
               MUL_OP_XSS, MUL_OP_XUU, MUL_OP_LO, MUL_OP_XSU};
        ve = '{32'h0000_0006, 32'h0000_0000, 32'h0000_0001, 32'h0000_003F,
               32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFF};

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_src1 = '0; in_src2 = '0; in_op = '0; in_tag = '0; exp_res = '0;

        #3;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        #19 reset_n = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'(1));
        step();

        // Single MUL, latency from accept to out_valid
        in_src1 = 32'h0001_0003; in_src2 = 32'h0002_0005; in_op = MUL_OP_LO;
        in_tag = 5'd7; exp_res = 32'h000B_000F; in_valid = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", 64'(lat), 64'(3));
        drain();

        // High-word modes and boundary operands
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_XUU, 5'd1, 32'hFFFF_FFFE);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_XSS, 5'd2, 32'h0000_0000);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_XSU, 5'd3, 32'hFFFF_FFFF);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_LO,  5'd4, 32'h0000_0001);
        issue(32'h8000_0000, 32'h8000_0000, MUL_OP_XSS, 5'd5, 32'h4000_0000);
        issue(32'h8000_0000, 32'h8000_0000, MUL_OP_XUU, 5'd6, 32'h4000_0000);
        issue(32'h8000_0000, 32'h8000_0000, MUL_OP_XSU, 5'd8, 32'hC000_0000);
        drain();

        // Back-to-back with out_ready low in cycles 4-6
        k = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            if (k < 8) begin
                in_src1 = va[k]; in_src2 = vb[k]; in_op = vo[k];
                in_tag = 5'(10 + k); exp_res = ve[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'(!(c >= 4 && c <= 6)));
            if (in_valid && in_ready) k++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_accepted", 64'(k), 64'(8));
        drain();

        // Flush with a stalled output and an op presented alongside
        out_ready = 1'b0;
        issue(32'h0000_0002, 32'h0000_0003, MUL_OP_LO, 5'd20, 32'h0000_0006);
        issue(32'h0000_0004, 32'h0000_0005, MUL_OP_LO, 5'd21, 32'h0000_0014);
        issue(32'h0000_0006, 32'h0000_0007, MUL_OP_LO, 5'd22, 32'h0000_002A);
        chk("fl_pre_stall", 64'(out_valid), 64'(1));
        flush = 1'b1; in_valid = 1'b1;
        in_src1 = 32'h0000_0003; in_src2 = 32'h0000_0003; in_op = MUL_OP_LO;
        in_tag = 5'd23; exp_res = 32'h0000_0009;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        repeat (6) step();

        // Flush with in_ready high: the presented op must be dropped
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd24;
        @(negedge clk);
        chk("fl_drop_in_ready", 64'(in_ready), 64'(1));
        step();
        flush = 1'b0; in_valid = 1'b0;
        repeat (6) step();
        issue(32'hFFFF_FFFE, 32'h0000_0003, MUL_OP_XSS, 5'd25, 32'hFFFF_FFFF);
        drain();

        // Asynchronous reset mid-stream with a held result
        out_ready = 1'b0;
        issue(32'h0000_0007, 32'h0000_0009, MUL_OP_LO, 5'd26, 32'h0000_003F);
        issue(32'h0001_0000, 32'h0001_0000, MUL_OP_XUU, 5'd27, 32'h0000_0001);
        repeat (3) step();
        chk("ar_pre_valid", 64'(out_valid), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'(0));
        chk("ar_out_result", 64'(out_result), 64'(0));
        chk("ar_out_tag", 64'(out_tag), 64'(0));
        sb.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1 chk("ar_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        repeat (8) step();
        issue(32'h0000_0007, 32'h0000_0009, MUL_OP_LO, 5'd30, 32'h0000_003F);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
